// File: rtl/pix_bus_pkg.sv
// pix_bus_pkg: shared mode/state encodings and pixel-to-byte address helper for the pixel bus
package pix_bus_pkg;
    typedef enum logic [1:0] {
        MODE_IDLE    = 2'b00,
        MODE_READ    = 2'b01,
        MODE_WRITE   = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
    localparam int ADDR_SHIFT = 2;
    function automatic logic [31:0] pix_addr(input logic [31:0] base, input logic [19:0] pix);
        return base + (32'(pix) << ADDR_SHIFT);
    endfunction
endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: counts WAIT cycles and flags when the bus transfer has hung too long
module bus_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;
    assign expired = cnt == CW'(TIMEOUT_CYC);
    // count enabled cycles, saturating at the timeout value
    always_ff @(posedge clk or posedge rst_i)
        if (rst_i) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + CW'(1);
endmodule

// File: rtl/pix_bus_arbiter.sv
// pix_bus_arbiter: round-robin sharing of the pixel bus between the RC4 and Sobel cores
module pix_bus_arbiter
    import pix_bus_pkg::*;
#(
    parameter logic [31:0] RD_BASE_0   = 32'h0000_0000,
    parameter logic [31:0] WR_BASE_0   = 32'h0010_0000,
    parameter logic [31:0] RD_BASE_1   = 32'h0010_0000,
    parameter logic [31:0] WR_BASE_1   = 32'h0020_0000,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [1:0]  req_mode_i    [0:1],
    input  logic [19:0] req_pix_num_i [0:1],
    input  logic [31:0] req_wdata_i   [0:1],
    output logic        req_dfb_o     [0:1],
    output logic [31:0] req_rdata_o,
    output logic        req_err_o,
    output logic        bus_req_o,
    output logic        bus_write_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_done_i,
    input  logic [31:0] bus_rdata_i,
    output logic        grant_o
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_WAIT  = WAIT;
    localparam logic [1:0] S_RESP  = RESP;
    logic [1:0]  st;
    logic        last_grant;
    logic        abort;
    logic [1:0]  ill_q;
    logic [1:0]  pend;
    logic [1:0]  ill;
    logic        g;
    logic        wr;
    logic [31:0] base;
    logic        expired;
    // pick the winner among legal requesters and its region base
    always_comb begin
        pend[0] = req_mode_i[0] == MODE_READ || req_mode_i[0] == MODE_WRITE;
        pend[1] = req_mode_i[1] == MODE_READ || req_mode_i[1] == MODE_WRITE;
        ill[0]  = req_mode_i[0] == MODE_ILLEGAL;
        ill[1]  = req_mode_i[1] == MODE_ILLEGAL;
        g       = (pend == 2'b11) ? ~last_grant : pend[1];
        wr      = req_mode_i[g] == MODE_WRITE;
        base    = g ? (wr ? WR_BASE_1 : RD_BASE_1) : (wr ? WR_BASE_0 : RD_BASE_0);
    end
    bus_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
        .clk(clk),
        .rst_i(rst_i),
        .clr(st == S_ISSUE),
        .en(st == S_WAIT),
        .expired(expired)
    );
    // transaction sequencer; every output is a register updated here
    always_ff @(posedge clk or posedge rst_i)
        if (rst_i) begin
            st           <= S_IDLE;
            last_grant   <= 1'b1;
            abort        <= 1'b0;
            ill_q        <= 2'b00;
            grant_o      <= 1'b0;
            req_dfb_o[0] <= 1'b0;
            req_dfb_o[1] <= 1'b0;
            req_err_o    <= 1'b0;
            req_rdata_o  <= '0;
            bus_req_o    <= 1'b0;
            bus_write_o  <= 1'b0;
            bus_addr_o   <= '0;
            bus_wdata_o  <= '0;
        end else begin
            req_dfb_o[0] <= 1'b0;
            req_dfb_o[1] <= 1'b0;
            req_err_o    <= 1'b0;
            case (st)
                S_IDLE: begin
                    ill_q     <= ill;
                    req_err_o <= |(ill & ~ill_q);
                    if (|pend) begin
                        grant_o     <= g;
                        bus_write_o <= wr;
                        bus_addr_o  <= pix_addr(base, req_pix_num_i[g]);
                        bus_wdata_o <= req_wdata_i[g];
                        abort       <= 1'b0;
                        st          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    bus_req_o <= 1'b1;
                    st        <= S_WAIT;
                end
                S_WAIT:
                    if (bus_done_i) begin
                        bus_req_o <= 1'b0;
                        if (!bus_write_o) req_rdata_o <= bus_rdata_i;
                        st <= S_RESP;
                    end else if (expired) begin
                        bus_req_o   <= 1'b0;
                        req_rdata_o <= '0;
                        abort       <= 1'b1;
                        st          <= S_RESP;
                    end
                default: begin
                    req_dfb_o[grant_o] <= 1'b1;
                    req_err_o          <= abort;
                    last_grant         <= grant_o;
                    st                 <= S_IDLE;
                end
            endcase
        end
endmodule

// File: tb/tb_pix_bus_arbiter.sv
// tb_pix_bus_arbiter: directed scenarios checked against a transaction-level model every cycle
module tb_pix_bus_arbiter;
    localparam int          TMO  = 4;
    localparam logic [31:0] RB0  = 32'h0000_0000;
    localparam logic [31:0] WB0  = 32'h0010_0000;
    localparam logic [31:0] RB1  = 32'h0010_0000;
    localparam logic [31:0] WB1  = 32'h0020_0000;
    localparam logic [31:0] RB0W = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  req_mode [0:1] = '{2'b00, 2'b00};
    logic [19:0] req_pix  [0:1] = '{20'h0, 20'h0};
    logic [31:0] req_wd   [0:1] = '{32'h0, 32'h0};
    logic        bus_done_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;

    logic        dfb [0:1];
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic        err, bus_req, bus_write, grant;
    logic        w_dfb [0:1];
    logic [31:0] w_rdata, w_addr, w_wdata;
    logic        w_err, w_req, w_write, w_grant;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pix_bus_arbiter #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_i(rst_i), .req_mode_i(req_mode), .req_pix_num_i(req_pix),
        .req_wdata_i(req_wd), .req_dfb_o(dfb), .req_rdata_o(rdata), .req_err_o(err),
        .bus_req_o(bus_req), .bus_write_o(bus_write), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_done_i(bus_done_i), .bus_rdata_i(bus_rdata_i),
        .grant_o(grant)
    );

    pix_bus_arbiter #(.TIMEOUT_CYC(TMO), .RD_BASE_0(RB0W)) dut_w (
        .clk(clk), .rst_i(rst_i), .req_mode_i(req_mode), .req_pix_num_i(req_pix),
        .req_wdata_i(req_wd), .req_dfb_o(w_dfb), .req_rdata_o(w_rdata), .req_err_o(w_err),
        .bus_req_o(w_req), .bus_write_o(w_write), .bus_addr_o(w_addr),
        .bus_wdata_o(w_wdata), .bus_done_i(bus_done_i), .bus_rdata_i(bus_rdata_i),
        .grant_o(w_grant)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: who wins, where the address lands, and the transaction timeline measured in edges
    logic [1:0]  m_p;
    logic        m_w, m_wr, m_last;
    logic [31:0] m_off, m_addr, m_addr_w;
    logic [1:0]  m_ill;
    int          age;
    logic        resp, e_abort;
    logic        e_grant, e_req, e_write, e_err;
    logic [1:0]  e_dfb;
    logic [31:0] e_addr, e_addr_w, e_wdata, e_rdata;

    // winner and byte address of the request the model would accept now
    always_comb begin
        m_p[0]   = req_mode[0] == 2'b01 || req_mode[0] == 2'b10;
        m_p[1]   = req_mode[1] == 2'b01 || req_mode[1] == 2'b10;
        m_w      = (m_p == 2'b11) ? !m_last : m_p[1];
        m_wr     = req_mode[m_w] == 2'b10;
        m_off    = {12'h0, req_pix[m_w]} * 32'd4;
        m_addr   = (m_wr ? (m_w ? WB1 : WB0) : (m_w ? RB1 : RB0)) + m_off;
        m_addr_w = (m_wr ? (m_w ? WB1 : WB0) : (m_w ? RB1 : RB0W)) + m_off;
    end

    // age = edges since grant (-1 when free); request up one edge after grant, done or timeout ends it
    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            age <= -1; resp <= 0; e_abort <= 0; m_last <= 1; m_ill <= 0;
            e_grant <= 0; e_req <= 0; e_write <= 0; e_err <= 0; e_dfb <= 0;
            e_addr <= 0; e_addr_w <= 0; e_wdata <= 0; e_rdata <= 0;
        end else begin
            e_dfb <= 0;
            e_err <= 0;
            if (resp) begin
                e_dfb[e_grant] <= 1;
                e_err <= e_abort;
                m_last <= e_grant;
                resp <= 0;
                age <= -1;
            end else if (age < 0) begin
                m_ill <= {req_mode[1] == 2'b11, req_mode[0] == 2'b11};
                e_err <= |({req_mode[1] == 2'b11, req_mode[0] == 2'b11} & ~m_ill);
                if (|m_p) begin
                    e_grant <= m_w; e_write <= m_wr; e_addr <= m_addr; e_addr_w <= m_addr_w;
                    e_wdata <= req_wd[m_w]; e_abort <= 0; age <= 0;
                end
            end else if (age == 0) begin
                e_req <= 1;
                age <= 1;
            end else if (bus_done_i) begin
                e_req <= 0;
                if (!e_write) e_rdata <= bus_rdata_i;
                resp <= 1;
            end else if (age == TMO + 1) begin
                e_req <= 0; e_rdata <= 0; e_abort <= 1; resp <= 1;
            end else
                age <= age + 1;
        end
    end

    // both instances must track the model on every cycle
    always @(negedge clk) begin
        chk("grant", 32'(grant), 32'(e_grant));
        chk("bus_req", 32'(bus_req), 32'(e_req));
        chk("bus_write", 32'(bus_write), 32'(e_write));
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_wdata", bus_wdata, e_wdata);
        chk("rdata", rdata, e_rdata);
        chk("dfb0", 32'(dfb[0]), 32'(e_dfb[0]));
        chk("dfb1", 32'(dfb[1]), 32'(e_dfb[1]));
        chk("err", 32'(err), 32'(e_err));
        chk("w_addr", w_addr, e_addr_w);
        chk("w_req", 32'(w_req), 32'(e_req));
        chk("w_rdata", w_rdata, e_rdata);
        chk("w_dfb", {30'h0, w_dfb[1], w_dfb[0]}, {30'h0, e_dfb});
        chk("w_err", 32'(w_err), 32'(e_err));
        chk("w_misc", {w_grant, w_write, w_wdata[29:0]}, {e_grant, e_write, e_wdata[29:0]});
    end

    // act as the bus: wait for the request, raise done in high-cycle 'dly' (0 = never)
    task automatic serve(input int dly, input logic [31:0] rd, output int hi);
        int n = 0;
        hi = 0;
        while (!bus_req && n < 10) begin @(negedge clk); n++; end
        chk("bus_req rise", 32'(bus_req), 1);
        chk("req latency", n, 2);
        while (bus_req && hi < 20) begin
            hi++;
            bus_done_i = (hi == dly);
            bus_rdata_i = rd;
            @(negedge clk);
            bus_done_i = 0;
        end
    endtask

    // wait for the completion pulse, check it, and drop the request like a requester would
    task automatic wait_dfb(input int r, input logic [31:0] rd, input logic er);
        int n = 0;
        while (!dfb[r] && n < 10) begin @(negedge clk); n++; end
        chk("dfb seen", 32'(dfb[r]), 1);
        chk("dfb latency", n, 1);
        chk("rdata at dfb", rdata, rd);
        chk("err at dfb", 32'(err), 32'(er));
        req_mode[r] = 2'b00;
    endtask

    task automatic do_reset();
        rst_i = 1;
        @(negedge clk);
        @(negedge clk);
        rst_i = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL global time limit");
        $fatal(1);
    end

    // directed scenarios
    initial begin
        int hi;
        @(negedge clk);
        @(negedge clk);
        chk("reset grant", 32'(grant), 0);
        chk("reset bus_req", 32'(bus_req), 0);
        chk("reset addr", bus_addr, 0);
        chk("reset rdata", rdata, 0);
        rst_i = 0;

        // single read, pix 5, done two cycles into WAIT
        req_mode[0] = 2'b01; req_pix[0] = 20'd5;
        serve(3, 32'h4869_5069, hi);
        chk("t1 high cycles", hi, 3);
        chk("t1 addr", bus_addr, 32'h0000_0014);
        chk("t1 write", 32'(bus_write), 0);
        chk("wrap addr", w_addr, 32'h0000_0004);
        wait_dfb(0, 32'h4869_5069, 0);
        @(negedge clk);
        chk("t1 dfb once", 32'(dfb[0]), 0);

        // contention from reset
        do_reset();
        req_mode[0] = 2'b01; req_pix[0] = 20'd0;
        req_mode[1] = 2'b10; req_pix[1] = 20'd3; req_wd[1] = 32'hA5A5_A5A5;
        serve(1, 32'h1111_2222, hi);
        chk("t2 first grant", 32'(grant), 0);
        chk("t2 first addr", bus_addr, 32'h0);
        wait_dfb(0, 32'h1111_2222, 0);
        serve(1, 32'h0, hi);
        chk("t2 second grant", 32'(grant), 1);
        chk("t2 second addr", bus_addr, 32'h0020_000C);
        chk("t2 second wdata", bus_wdata, 32'hA5A5_A5A5);
        chk("t2 second write", 32'(bus_write), 1);
        wait_dfb(1, 32'h1111_2222, 0);
        req_mode[0] = 2'b01; req_pix[0] = 20'd9;
        req_mode[1] = 2'b01; req_pix[1] = 20'd7;
        serve(2, 32'h0000_0909, hi);
        chk("t2 third tie grant", 32'(grant), 0);
        chk("t2 third addr", bus_addr, 32'h0000_0024);
        wait_dfb(0, 32'h0000_0909, 0);
        serve(1, 32'h0707_0707, hi);
        chk("t2 fourth grant", 32'(grant), 1);
        chk("t2 fourth addr", bus_addr, 32'h0010_001C);
        wait_dfb(1, 32'h0707_0707, 0);

        // timeout with no done, then done on the last allowed WAIT cycle
        req_mode[0] = 2'b10; req_pix[0] = 20'd2; req_wd[0] = 32'hDEAD_BEEF;
        serve(0, 32'hFFFF_FFFF, hi);
        chk("t3 high cycles", hi, 5);
        chk("t3 addr", bus_addr, 32'h0010_0008);
        wait_dfb(0, 32'h0, 1);
        req_mode[1] = 2'b01; req_pix[1] = 20'd1;
        serve(5, 32'hCAFE_0001, hi);
        chk("t3 late done cycles", hi, 5);
        wait_dfb(1, 32'hCAFE_0001, 0);

        // illegal mode on requester 1
        req_mode[1] = 2'b11;
        @(negedge clk);
        chk("t4 err pulse", 32'(err), 1);
        chk("t4 no bus", 32'(bus_req), 0);
        req_mode[1] = 2'b00;
        req_mode[0] = 2'b01; req_pix[0] = 20'd4;
        serve(1, 32'h0BAD_F00D, hi);
        chk("t4 grant", 32'(grant), 0);
        chk("t4 addr", bus_addr, 32'h0000_0010);
        wait_dfb(0, 32'h0BAD_F00D, 0);

        // reset while the bus request is held
        req_mode[0] = 2'b01; req_pix[0] = 20'd6;
        for (int i = 0; i < 10 && !bus_req; i++) @(negedge clk);
        @(negedge clk);
        chk("t5 req before reset", 32'(bus_req), 1);
        rst_i = 1;
        #1;
        chk("t5 req drop", 32'(bus_req), 0);
        chk("t5 no dfb", 32'(dfb[0]), 0);
        req_mode[0] = 2'b00;
        req_mode[1] = 2'b01; req_pix[1] = 20'd8;
        @(negedge clk);
        @(negedge clk);
        rst_i = 0;
        serve(1, 32'h7777_0008, hi);
        chk("t5 lone grant", 32'(grant), 1);
        chk("t5 addr", bus_addr, 32'h0010_0020);
        wait_dfb(1, 32'h7777_0008, 0);
        req_mode[0] = 2'b01; req_pix[0] = 20'd1;
        req_mode[1] = 2'b01; req_pix[1] = 20'd2;
        serve(1, 32'h1, hi);
        chk("t5 tie grant", 32'(grant), 0);
        wait_dfb(0, 32'h1, 0);
        serve(1, 32'h2, hi);
        wait_dfb(1, 32'h2, 0);
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
